// File: rtl/mux_pkg.sv
// Shared types and defaults for the mux_n_scan channel multiplexer.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int N_CH_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DWELL_DEF = 4;

endpackage

// File: rtl/mux_n_scan_if.sv
// Control/data bundle between a channel source and mux_n_scan.
interface mux_n_scan_if
  import mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int SW = $clog2(N_CH);

  logic                  EN;
  logic                  MODE;
  logic [SW-1:0]         SEL;
  logic [N_CH*WIDTH-1:0] D;
  logic [WIDTH-1:0]      F;
  logic [SW-1:0]         CH;
  logic                  STROBE;
  logic                  VALID;

  modport master (output EN, MODE, SEL, D, input F, CH, STROBE, VALID);
  modport slave  (input EN, MODE, SEL, D, output F, CH, STROBE, VALID);
endinterface

// File: rtl/scan_ctr.sv
// Dwell counter plus wrapping channel counter. The channel register is also
// the CH output in manual mode: any non-advancing cycle simply loads it.
module scan_ctr
  import mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [$clog2(N_CH)-1:0] load_ch,
  output logic [$clog2(N_CH)-1:0] ch,
  output logic                    strobe
);
  localparam int SW       = $clog2(N_CH);
  localparam int DW       = $clog2(DWELL);
  localparam int LAST_I   = N_CH - 1;
  localparam int DLAST_I  = DWELL - 1;
  localparam logic [SW-1:0] LAST  = LAST_I[SW-1:0];
  localparam logic [DW-1:0] DLAST = DLAST_I[DW-1:0];

  logic [DW-1:0] dwell;

  // Load restarts the dwell; otherwise count dwell and advance/wrap channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell  <= '0;
      ch     <= '0;
      strobe <= 1'b0;
    end else if (!en) begin
      strobe <= 1'b0;
    end else if (load) begin
      ch     <= load_ch;
      dwell  <= '0;
      strobe <= 1'b0;
    end else if (dwell == DLAST) begin
      dwell  <= '0;
      ch     <= (ch == LAST) ? '0 : ch + 1'b1;
      strobe <= 1'b1;
    end else begin
      dwell  <= dwell + 1'b1;
      strobe <= 1'b0;
    end
  end
endmodule

// File: rtl/mux_n_scan.sv
// N-channel registered multiplexer with manual select and timed auto-scan.
// Optional macro MUX_N_SCAN_BLANK_EN blanks F for one cycle after each
// scan advance (ghost suppression on multiplexed displays).
//
// state  | meaning
// IDLE   | after reset, nothing loaded yet (VALID=0)
// MANUAL | F/CH follow SEL with one cycle latency
// SCAN   | channel steps every DWELL enabled cycles, F follows that channel
module mux_n_scan
  import mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input logic         CLK,
  input logic         RST,
  mux_n_scan_if.slave bus
);
  localparam int SW = $clog2(N_CH);
  localparam logic [SW:0] NCH_L = N_CH[SW:0];

  state_t           state;
  logic [WIDTH-1:0] f_q;
  logic             valid_q;
  logic [SW-1:0]    ch;
  logic             strobe;
  logic             run;
  logic             load;
  logic [SW-1:0]    start_ch;
  logic [SW-1:0]    load_ch;

  // Out-of-range indices select zero.
  function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] d,
                                            input logic [SW-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == k[SW-1:0]) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Decide whether the counter advances (steady scan) or loads a channel.
  always_comb begin
    start_ch = ({1'b0, bus.SEL} < NCH_L) ? bus.SEL : '0;
    run      = (state == SCAN) && (bus.MODE == MODE_SCAN);
    load     = !run;
    load_ch  = (bus.MODE == MODE_SCAN) ? start_ch : bus.SEL;
  end

  scan_ctr #(.N_CH(N_CH), .DWELL(DWELL)) u_scan_ctr (
    .clk     (CLK),
    .rst     (RST),
    .en      (bus.EN),
    .load    (load),
    .load_ch (load_ch),
    .ch      (ch),
    .strobe  (strobe)
  );

  // Mode FSM with registered data output and valid flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      f_q     <= '0;
      valid_q <= 1'b0;
    end else if (bus.EN) begin
      valid_q <= 1'b1;
      if (run) begin
        state <= SCAN;
`ifdef MUX_N_SCAN_BLANK_EN
        f_q <= strobe ? '0 : pick(bus.D, ch);
`else
        f_q <= pick(bus.D, ch);
`endif
      end else if (bus.MODE == MODE_MANUAL) begin
        state <= MANUAL;
        f_q   <= pick(bus.D, bus.SEL);
      end else begin
        state <= SCAN;
        f_q   <= pick(bus.D, start_ch);
      end
    end
  end

  assign bus.F      = f_q;
  assign bus.CH     = ch;
  assign bus.STROBE = strobe;
  assign bus.VALID  = valid_q;
endmodule

// File: tb/tb_mux_n_scan.sv
// Bench for mux_n_scan: two instances (4 and 3 channels) share stimulus;
// an arithmetic model predicts every output each cycle.
module tb_mux_n_scan;
  localparam int DWELL = 4;
`ifdef MUX_N_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    int mode;   // 0 idle, 1 manual, 2 scan
    int start;
    int n;      // enabled scan cycles since entry
    int ch;
    int strobe;
    int valid;
    int f;
  } mdl_t;

  logic        CLK = 1'b0;
  logic        rst, en, mode;
  logic [1:0]  sel;
  logic [31:0] d;
  int          checks = 0;
  int          failures = 0;
  bit          run_cmp = 1'b0;
  int          strobes;
  mdl_t        ma, mb;

  always #5 CLK = ~CLK;

  mux_n_scan_if #(.N_CH(4), .WIDTH(8)) ifa ();
  mux_n_scan_if #(.N_CH(3), .WIDTH(8)) ifb ();

  assign ifa.EN = en;  assign ifa.MODE = mode;  assign ifa.SEL = sel;  assign ifa.D = d;
  assign ifb.EN = en;  assign ifb.MODE = mode;  assign ifb.SEL = sel;  assign ifb.D = d[23:0];

  mux_n_scan #(.N_CH(4), .WIDTH(8), .DWELL(DWELL)) dut_a (.CLK(CLK), .RST(rst), .bus(ifa));
  mux_n_scan #(.N_CH(3), .WIDTH(8), .DWELL(DWELL)) dut_b (.CLK(CLK), .RST(rst), .bus(ifb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int dget(input logic [31:0] dv, input int k);
    logic [31:0] t;
    t = dv >> (k * 8);
    return int'(t[7:0]);
  endfunction

  function automatic void step(inout mdl_t m, input int nch, input logic r, e, md,
                               input int s, input logic [31:0] dv);
    bit blank;
    if (r) begin
      m.mode = 0; m.f = 0; m.ch = 0; m.strobe = 0; m.valid = 0; m.n = 0; m.start = 0;
    end else if (!e) begin
      m.strobe = 0;
    end else begin
      m.valid = 1;
      if (!md) begin
        m.mode = 1; m.ch = s; m.f = (s < nch) ? dget(dv, s) : 0; m.strobe = 0;
      end else if (m.mode != 2) begin
        m.mode = 2; m.start = (s < nch) ? s : 0; m.n = 0;
        m.ch = m.start; m.f = dget(dv, m.start); m.strobe = 0;
      end else begin
        blank = BLANK && (m.n > 0) && (m.n % DWELL == 0);
        m.f = blank ? 0 : dget(dv, (m.start + m.n / DWELL) % nch);
        m.n++;
        m.ch = (m.start + m.n / DWELL) % nch;
        m.strobe = (m.n % DWELL == 0) ? 1 : 0;
      end
    end
  endfunction

  // Model advances on the same edge the DUT registers.
  always @(posedge CLK) begin
    step(ma, 4, rst, en, mode, int'(sel), d);
    step(mb, 3, rst, en, mode, int'(sel), d);
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge CLK) begin
    if (run_cmp) begin
      chk("a_f", 32'(ifa.F), ma.f);        chk("a_ch", 32'(ifa.CH), ma.ch);
      chk("a_strobe", 32'(ifa.STROBE), ma.strobe); chk("a_valid", 32'(ifa.VALID), ma.valid);
      chk("b_f", 32'(ifb.F), mb.f);        chk("b_ch", 32'(ifb.CH), mb.ch);
      chk("b_strobe", 32'(ifb.STROBE), mb.strobe); chk("b_valid", 32'(ifb.VALID), mb.valid);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  int exp_ch [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; d = 32'h0;
    cyc(); cyc();
    run_cmp = 1'b1;
    chk("rst_f", 32'(ifa.F), 0);         chk("rst_ch", 32'(ifa.CH), 0);
    chk("rst_valid", 32'(ifa.VALID), 0); chk("rst_strobe", 32'(ifa.STROBE), 0);

    // First manual load
    rst = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd2; d = 32'hDEA5773C;
    cyc();
    chk("man_f_a5", 32'(ifa.F), 32'hA5); chk("man_ch2", 32'(ifa.CH), 2);
    chk("man_valid", 32'(ifa.VALID), 1); chk("b_man_f_a5", 32'(ifb.F), 32'hA5);

    // Manual sweep including out-of-range index on the 3-channel instance
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      cyc();
    end
    chk("b_sel3_f0", 32'(ifb.F), 0);  chk("b_sel3_ch", 32'(ifb.CH), 3);
    chk("a_sel3_f", 32'(ifa.F), 32'hDE);

    // Scan from channel 0 for 20 enabled cycles
    sel = 2'd0; mode = 1'b1; d = 32'h44332211; strobes = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i % 4 == 0) chk("scan_ch_seq", 32'(ifa.CH), exp_ch[i / 4]);
      strobes += int'(ifa.STROBE);
    end
    chk("scan_strobe_cnt", strobes, 4);

    // Back to manual, then scan from SEL=3
    mode = 1'b0; sel = 2'd3; cyc();
    mode = 1'b1; d = 32'h9C8B7A69; cyc();
    chk("b_start_ch0", 32'(ifb.CH), 0); chk("a_start_ch3", 32'(ifa.CH), 3);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 8) chk("b_ch2", 32'(ifb.CH), 2);
    end
    chk("b_wrap_ch0", 32'(ifb.CH), 0); chk("a_wrap_ch2", 32'(ifa.CH), 2);
    cyc(); cyc();

    // Freeze at dwell count 2
    en = 1'b0; d = 32'h55667788;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("frz_ch", 32'(ifa.CH), 2); chk("frz_strobe", 32'(ifa.STROBE), 0);
    end
    en = 1'b1;
    cyc(); chk("resume_no_strobe", 32'(ifa.STROBE), 0);
    cyc(); chk("resume_strobe", 32'(ifa.STROBE), 1); chk("resume_ch3", 32'(ifa.CH), 3);
    cyc(); cyc();

    // Reset mid-scan at CH=1, dwell 2
    rst = 1'b1; cyc();
    rst = 1'b0; mode = 1'b1; sel = 2'd1; en = 1'b1; d = 32'h12345678;
    cyc(); cyc(); cyc();
    chk("pre_rst_ch1", 32'(ifa.CH), 1);
    rst = 1'b1; cyc();
    chk("mid_rst_f", 32'(ifa.F), 0);       chk("mid_rst_ch", 32'(ifa.CH), 0);
    chk("mid_rst_valid", 32'(ifa.VALID), 0); chk("mid_rst_strobe", 32'(ifa.STROBE), 0);
    rst = 1'b0; mode = 1'b0; sel = 2'd3; cyc(); cyc();

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_n_scan.md
MUX_N_SCAN -- requirements
Module: mux_n_scan

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high; clock port CLK, reset port RST.
REQ-002 Parameter N_CH, default 4, SHALL set the input channel count, from 2 to 16; non-power-of-2 values SHALL be legal.
REQ-003 Parameter WIDTH, default 8, SHALL set the bits per channel, from 1 to 32.
REQ-004 Parameter DWELL, default 4, SHALL set the clock cycles per channel in scan mode, with DWELL >= 2.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 EN  input  1  clock enable; when low, all state SHALL freeze.
REQ-008 MODE  input  1  0 = manual select, 1 = auto-scan.
REQ-009 SEL  input  SW=$clog2(N_CH)  manual channel index.
REQ-010 D  input  N_CH*WIDTH  packed channel data; channel k SHALL occupy bits [k*WIDTH +: WIDTH].
REQ-011 F  output  WIDTH  registered selected data.
REQ-012 CH  output  SW  index of the channel currently driving F.
REQ-013 STROBE  output  1  one-cycle pulse on each scan channel advance.
REQ-014 VALID  output  1  high while F holds a loaded value.

Function
REQ-015 FSM states SHALL be IDLE, MANUAL and SCAN; IDLE SHALL be entered only via RST.
REQ-016 From IDLE, the first EN=1 cycle SHALL go to MANUAL (MODE=0) or SCAN (MODE=1).
REQ-017 MANUAL->SCAN SHALL occur on the first EN=1 cycle with MODE=1, and SCAN->MANUAL on the first EN=1 cycle with MODE=0; each switch SHALL take effect in that same cycle's register update.
REQ-018 In MANUAL, latency SHALL be 1 cycle: F<=D[SEL] and CH<=SEL each EN=1 cycle.
REQ-019 In MANUAL, if SEL>=N_CH then F<=0 and CH<=SEL.
REQ-020 On SCAN entry, the start channel SHALL be SEL if SEL<N_CH, else 0; the dwell counter SHALL clear to 0.
REQ-021 In SCAN, F<=D[CH] every EN=1 cycle, so live data changes SHALL track within 1 cycle.
REQ-022 In SCAN, the dwell counter SHALL count 0..DWELL-1; on reaching DWELL-1 the counter SHALL return to 0, CH SHALL advance by 1, and STROBE SHALL be 1 for that cycle.
REQ-023 CH SHALL wrap from N_CH-1 to 0, never taking values >= N_CH in SCAN.
REQ-024 STROBE SHALL be 0 in IDLE and MANUAL, and whenever EN=0.
REQ-025 VALID SHALL rise on the first loading cycle after IDLE and stay high until RST.
REQ-026 When EN=0, F, CH, VALID, the dwell counter and the state SHALL hold.
REQ-027 RST SHALL take priority over EN and MODE.

Reset
REQ-028 On RST=1 at a rising CLK edge: F=0, CH=0, STROBE=0, VALID=0, dwell counter=0, state=IDLE.
REQ-029 RST asserted mid-scan SHALL abandon the dwell count with no STROBE.

Configuration
REQ-030 Macro MUX_N_SCAN_BLANK_EN, when defined, SHALL force F=0 in the cycle each scan advance lands (the cycle after STROBE), as ghost blanking for multiplexed displays; data SHALL resume the following cycle.
REQ-031 Without MUX_N_SCAN_BLANK_EN, F SHALL switch directly to the new channel's data with no blank cycle.
REQ-032 MANUAL behaviour SHALL be identical with or without the macro.

Structure
REQ-033 Package mux_pkg SHALL hold the state enum typedef (IDLE/MANUAL/SCAN), the mode constants and the default parameter constants.
REQ-034 Sub-module scan_ctr SHALL implement the dwell counter and the wrapping channel counter, with STROBE as its output.

Verification
REQ-035 RST=1 for 2 cycles, then EN=1, MODE=0, SEL=2, D ch2=8'hA5 -> one cycle later F=A5, CH=2, VALID=1.
REQ-036 N_CH=4, DWELL=4, MODE=1, SEL=0, EN=1 for 20 cycles -> CH sequence 0,1,2,3,0 at 4-cycle intervals, with exactly 4 STROBE pulses after scan entry.
REQ-037 N_CH=3, manual SEL=3 -> F=0; then scan from SEL=3 -> scan starts at CH=0 and wraps 2->0.
REQ-038 Mid-scan EN=0 for 5 cycles -> F, CH and dwell counter frozen with STROBE=0; scan resumes with the remaining dwell count.
REQ-039 RST at dwell count 2 of CH=1 -> next cycle F=0, CH=0, VALID=0 and no STROBE.
REQ-040 With MUX_N_SCAN_BLANK_EN defined -> F=0 in the cycle after each STROBE; without it -> F never 0 unless D is 0.
